trim_dac_rx: RTL and testbench
==============================

Name: trim_dac_rx

Overview:
- Receiver/decoder for the trim-DAC serial link: the far end of the 3-chip LTC2624 daisy chain.
- Sits on the board-test/loopback path. It samples the DAC chain's serial data, clock and active-low enable, then reconstructs the 9 trim-DAC codes exactly as the chips would latch them.
- Gives firmware and the verification bench an independent readback of what the trim-DAC controller transmitted, with framing and command checking.

Parameters:
- N_CHIPS, 3, number of 32-bit words per frame (chips in chain).
- N_DACS_PER_CHIP, 3, DAC addresses decoded per chip (A, B, C); address D is accepted but discarded.
- SYNC_STAGES, 2, synchroniser depth on sclk, sdi, cs_n (minimum 2).

Ports:
- clk160 input 1: system clock. sclk must be at most clk160/4 (the 20 MHz link is supported).
- rst_n input 1: asynchronous, active-low reset.
- sdi input 1: serial data from the chain, asynchronous.
- sclk input 1: DAC chip serial clock, asynchronous. Data is sampled on its rising edge.
- cs_n input 1: DAC chip enable, active low, asynchronous.
- dac_codes output 108: 9 x 12-bit output registers. Channel k is at [12k+11:12k], k = 0..8.
- frame_valid output 1: one-cycle pulse, a good 96-bit frame was decoded.
- frame_err output 1: one-cycle pulse, the frame had the wrong bit count.
- cmd_err output 1: one-cycle pulse, at least one word in the frame had an unsupported command or address.
- frame_cnt output 16: count of good frames, wraps at 0xFFFF -> 0.
- sdo output 1: daisy-chain echo (see Optional Feature).

Behaviour:
- Reset (async, rst_n = 0):
  - Synchronisers preset to the idle line state: sclk = 0, cs_n = 1, sdi = 0.
  - Shift register, bit counter, input/output code registers, frame_cnt, all pulses and sdo go to 0.
- Edge detection: sclk and cs_n pass through SYNC_STAGES flops. Edges are detected from the last stage and its one-cycle-delayed copy.
- FSM states:
  - IDLE -> SHIFT on cs_n falling edge: bit counter cleared.
  - SHIFT, on each sclk rising edge: shreg <= {shreg[94:0], sdi_sync}. The 7-bit counter increments and saturates at 127.
  - SHIFT -> DECODE on cs_n rising edge.
  - DECODE -> IDLE always, after exactly one cycle.
- An sclk rising edge in the same cycle as the cs_n rising edge is still shifted in, before decode.
- sclk edges while in IDLE are ignored.
- Framing, evaluated in DECODE:
  - Count 0: no pulses, no update.
  - Count not 0 and not 96: frame_err = 1, no register change.
  - Count exactly 96: decode all words.
- Word mapping:
  - First-received word shreg[95:64] belongs to chip 3, shreg[63:32] to chip 2, shreg[31:0] to chip 1.
  - Per word: [31:24] don't care, [23:20] command, [19:16] address, [15:4] code, [3:0] don't care.
  - Channel index = 3*(chip-1) + address, for address 0..2.
- Commands, each word decoded independently:
  - 0000: write the input register only.
  - 0001: copy the input register to the output register.
  - 0010: write the input register, then update all 3 outputs of that chip from their input registers.
  - 0011: write and update the addressed channel.
  - 1111: no-op.
  - Any other command, or address 4..15: that word is ignored and cmd_err = 1.
  - Address 3 (DAC D) is valid and silently ignored.
- Outputs and latency:
  - dac_codes, frame_valid and frame_cnt update on the DECODE cycle edge. This is 1 clk160 after the synchronised cs_n rising edge, and at most SYNC_STAGES + 2 cycles after the pin edge.
  - On a 96-bit frame, frame_valid is asserted even when cmd_err is also asserted.
- Reset mid-frame: the partial frame is discarded. After rst_n releases, the FSM waits in IDLE for a fresh cs_n falling edge. If cs_n is already low at release, nothing is captured until the next falling edge.
- A cs_n glitch (fall, then rise, no sclk) counts as a count-0 frame: silent.

Optional Feature:
- Macro TRIM_RX_ECHO_EN.
- Defined: sdo carries shreg[95] and is updated on each synchronised sclk falling edge while in SHIFT. This matches LTC2624 SDO daisy behaviour delayed by 96 bits, so a second receiver can be chained. sdo is held 0 in IDLE.
- Not defined: sdo tied to 0 and the echo logic is absent.

Test Plan:
- Good frame, command 3:
  - Stimulus: one frame of words 0x0030ABC0 (chip 3), 0x00301230 (chip 2), 0x00300FF0 (chip 1) at 20 MHz sclk.
  - Required: ch6 = 0xABC, ch3 = 0x123, ch0 = 0x0FF; frame_valid pulses once; frame_cnt = 1.
- Full sweep:
  - Stimulus: three frames for address 0, 1, 2 with codes 0x100..0x108.
  - Required: all 9 channels match; frame_cnt = 3; no error pulses.
- Short frame:
  - Stimulus: 95 sclk edges, then cs_n high.
  - Required: frame_err pulse; dac_codes unchanged; frame_cnt unchanged.
- Staged write/update:
  - Stimulus: frame with command 0000, code 0x555 to chip 1 address 1; then command 0001 to the same address.
  - Required: ch1 stays at its old value after the first frame and is 0x555 after the second.
- Bad command:
  - Stimulus: command 0101 in the chip 2 word, valid command 3 words for chips 1 and 3.
  - Required: cmd_err and frame_valid both pulse; chips 1 and 3 updated; chip 2 channels unchanged.
- Reset at bit 40, then recovery:
  - Stimulus: rst_n asserted at bit 40 of a frame, followed by a complete good frame.
  - Required: all outputs 0 immediately after reset; only the second frame is decoded; frame_cnt = 1.
  - With TRIM_RX_ECHO_EN defined: sdo reproduces sdi delayed by 96 bits.

Source files
------------

// File: rtl/trim_dac_rx.sv
// Loopback receiver for the 3-chip LTC2624 trim-DAC daisy chain: rebuilds the latched DAC codes.
// Optional TRIM_RX_ECHO_EN: sdo re-transmits the chain data delayed by one full frame.
module trim_dac_rx #(
    parameter int N_CHIPS         = 3,
    parameter int N_DACS_PER_CHIP = 3,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                                    clk160,
    input  logic                                    rst_n,
    input  logic                                    sdi,
    input  logic                                    sclk,
    input  logic                                    cs_n,
    output logic [12*N_CHIPS*N_DACS_PER_CHIP-1:0]   dac_codes,
    output logic                                    frame_valid,
    output logic                                    frame_err,
    output logic                                    cmd_err,
    output logic [15:0]                             frame_cnt,
    output logic                                    sdo,
    output logic [1:0]                              o_dbg_state
);
    localparam int         FB       = 32 * N_CHIPS;
    localparam int         N_CH     = N_CHIPS * N_DACS_PER_CHIP;
    localparam int         IDX_W    = $clog2(N_CH);
    localparam logic [6:0] CNT_FULL = 7'(FB);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DECODE} state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_sdi_sync;
    logic [SYNC_STAGES:0]   r_fill;
    logic                   r_sclk_d, r_cs_d, r_armed;
    logic [FB-1:0]          r_shreg;
    logic [6:0]             r_cnt;
    logic [11:0]            r_in [N_CH];
    logic [11:0]            r_out [N_CH];
    logic [11:0]            w_in_nx [N_CH];
    logic [11:0]            w_out_nx [N_CH];
    logic                   r_frame_valid, r_frame_err, r_cmd_err;
    logic [15:0]            r_frame_cnt;
    logic                   w_sclk, w_cs, w_sdi;
    logic                   w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic                   w_cmd_bad, w_addr_dac;
    logic [3:0]             w_cmd, w_addr;
    logic [11:0]            w_code;
    logic [IDX_W-1:0]       w_base, w_idx;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    // Falls are only trusted once real pin values have reached both edge flops and cs_n was seen high,
    // so a cs_n already low at reset release never opens a frame.
    assign w_cs_fall   = ~w_cs & r_cs_d & r_armed;

    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_sdi_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_fill      <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
            r_fill      <= {r_fill[SYNC_STAGES-1:0], 1'b1};
            r_armed     <= r_armed | (r_fill[SYNC_STAGES] & w_cs & r_cs_d);
        end
    end

    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_cs_fall) w_next = S_SHIFT;
            S_SHIFT:  if (w_cs_rise) w_next = S_DECODE;
            S_DECODE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign o_dbg_state = r_state;

    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_IDLE && w_cs_fall) begin
            r_cnt <= '0;
        end else if (r_state == S_SHIFT && w_sclk_rise) begin
            r_shreg <= {r_shreg[FB-2:0], w_sdi};
            if (r_cnt != 7'd127) r_cnt <= r_cnt + 7'd1;
        end
    end

    // Words decode independently; word c sits at [32c+31:32c] and belongs to chip c+1.
    always_comb begin
        w_in_nx    = r_in;
        w_out_nx   = r_out;
        w_cmd_bad  = 1'b0;
        w_cmd      = '0;
        w_addr     = '0;
        w_code     = '0;
        w_base     = '0;
        w_idx      = '0;
        w_addr_dac = 1'b0;
        for (int c = 0; c < N_CHIPS; c++) begin
            w_cmd      = r_shreg[32*c+20 +: 4];
            w_addr     = r_shreg[32*c+16 +: 4];
            w_code     = r_shreg[32*c+4 +: 12];
            w_base     = IDX_W'(c * N_DACS_PER_CHIP);
            w_idx      = w_base + IDX_W'(w_addr);
            w_addr_dac = (w_addr < 4'(N_DACS_PER_CHIP));
            if (w_addr > 4'd3) begin
                w_cmd_bad = 1'b1;
            end else begin
                case (w_cmd)
                    4'h0: if (w_addr_dac) w_in_nx[w_idx] = w_code;
                    4'h1: if (w_addr_dac) w_out_nx[w_idx] = w_in_nx[w_idx];
                    4'h2: begin
                        if (w_addr_dac) w_in_nx[w_idx] = w_code;
                        for (int a = 0; a < N_DACS_PER_CHIP; a++)
                            w_out_nx[w_base + IDX_W'(a)] = w_in_nx[w_base + IDX_W'(a)];
                    end
                    4'h3: if (w_addr_dac) begin
                        w_in_nx[w_idx]  = w_code;
                        w_out_nx[w_idx] = w_code;
                    end
                    4'hF: ;
                    default: w_cmd_bad = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                r_in[k]  <= '0;
                r_out[k] <= '0;
            end
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_cmd_err     <= 1'b0;
            if (r_state == S_DECODE) begin
                if (r_cnt == CNT_FULL) begin
                    r_in          <= w_in_nx;
                    r_out         <= w_out_nx;
                    r_frame_valid <= 1'b1;
                    r_cmd_err     <= w_cmd_bad;
                    r_frame_cnt   <= r_frame_cnt + 16'd1;
                end else if (r_cnt != 7'd0) begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        dac_codes = '0;
        for (int k = 0; k < N_CH; k++) dac_codes[12*k +: 12] = r_out[k];
    end

    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign cmd_err     = r_cmd_err;
    assign frame_cnt   = r_frame_cnt;

`ifdef TRIM_RX_ECHO_EN
    logic r_sdo;
    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n)                                     r_sdo <= 1'b0;
        else if (r_state == S_IDLE)                     r_sdo <= 1'b0;
        else if (r_state == S_SHIFT && w_sclk_fall)     r_sdo <= r_shreg[FB-1];
    end
    assign sdo = r_sdo;
`else
    logic w_unused_msb;
    assign w_unused_msb = r_shreg[FB-1];
    assign sdo          = 1'b0;
`endif
endmodule

// File: tb/tb_trim_dac_rx.sv
// Bench for trim_dac_rx: random and directed frames, scoreboard against a frame-level model.
module tb_trim_dac_rx;
  logic         clk160 = 1'b0;
  logic         rst_n  = 1'b0;
  logic         sdi    = 1'b0;
  logic         sclk   = 1'b0;
  logic         cs_n   = 1'b1;
  logic [107:0] dac_codes;
  logic         frame_valid, frame_err, cmd_err, sdo;
  logic [15:0]  frame_cnt;
  logic [1:0]   dbg_state;

  trim_dac_rx dut (
    .clk160(clk160), .rst_n(rst_n), .sdi(sdi), .sclk(sclk), .cs_n(cs_n),
    .dac_codes(dac_codes), .frame_valid(frame_valid), .frame_err(frame_err),
    .cmd_err(cmd_err), .frame_cnt(frame_cnt), .sdo(sdo), .o_dbg_state(dbg_state)
  );

  // clock/reset
  always #3 clk160 = ~clk160;

  int checks = 0;
  int errors = 0;

  // expected entry: {frame_valid, frame_err, cmd_err, frame_cnt[15:0], dac_codes[107:0]}
  logic [126:0] exp_q[$];
  logic [11:0]  m_in [9];
  logic [11:0]  m_out [9];
  logic [15:0]  m_cnt;
  logic         hist[$];
  bit           track = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [107:0] model_codes();
    logic [107:0] v;
    for (int k = 0; k < 9; k++) v[12*k +: 12] = m_out[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) begin
      m_in[k]  = '0;
      m_out[k] = '0;
    end
    m_cnt = '0;
    hist.delete();
    repeat (96) hist.push_back(1'b0);
  endtask

  // Frame-level rules: bit count decides framing, each chip word applies its command on its own channels.
  task automatic predict(input logic [255:0] bits, input int nbits);
    logic [31:0] w;
    logic [3:0]  cmd, addr;
    logic [11:0] code;
    logic        ce;
    int          ch;
    if (nbits == 0) return;
    if (nbits != 96) begin
      exp_q.push_back({1'b0, 1'b1, 1'b0, m_cnt, model_codes()});
      return;
    end
    ce = 1'b0;
    for (int chip = 1; chip <= 3; chip++) begin
      w    = bits[32*(chip-1) +: 32];
      cmd  = w[23:20];
      addr = w[19:16];
      code = w[15:4];
      ch   = 3 * (chip - 1) + int'(addr);
      if (addr > 3) ce = 1'b1;
      else if (cmd == 4'h0) begin
        if (addr < 3) m_in[ch] = code;
      end else if (cmd == 4'h1) begin
        if (addr < 3) m_out[ch] = m_in[ch];
      end else if (cmd == 4'h2) begin
        if (addr < 3) m_in[ch] = code;
        for (int a = 0; a < 3; a++) m_out[3*(chip-1)+a] = m_in[3*(chip-1)+a];
      end else if (cmd == 4'h3) begin
        if (addr < 3) begin
          m_in[ch]  = code;
          m_out[ch] = code;
        end
      end else if (cmd != 4'hF) ce = 1'b1;
    end
    m_cnt = m_cnt + 16'd1;
    exp_q.push_back({1'b1, 1'b0, ce, m_cnt, model_codes()});
  endtask

  // driver: one 20 MHz sclk period, data changes on the falling edge
  task automatic sclk_bit(input logic b, input bit first);
    logic exp_sdo;
    sdi = b;
    #25;
    sclk = 1'b1;
    #10;
`ifdef TRIM_RX_ECHO_EN
    exp_sdo = (track && !first) ? hist[hist.size()-96] : 1'b0;
`else
    exp_sdo = 1'b0;
`endif
    check("sdo", sdo, exp_sdo);
    if (track) hist.push_back(b);
    #15;
    sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [255:0] bits, input int nbits);
    track = 1'b1;
    cs_n  = 1'b0;
    #50;
    for (int i = nbits - 1; i >= 0; i--) sclk_bit(bits[i], i == nbits - 1);
    #25;
    predict(bits, nbits);
    cs_n = 1'b1;
    #300;
    track = 1'b0;
  endtask

  function automatic logic [31:0] mkw(input logic [3:0] cmd, input logic [3:0] addr, input logic [11:0] code);
    return {8'h00, cmd, addr, code, 4'h0};
  endfunction

  function automatic logic [255:0] mkf(input logic [31:0] c3, input logic [31:0] c2, input logic [31:0] c1);
    return {160'h0, c3, c2, c1};
  endfunction

  function automatic logic [255:0] rnd_bits();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // scoreboard monitor: one pop per reported pulse cycle
  always @(negedge clk160) begin
    logic [126:0] e;
    if (rst_n && (frame_valid || frame_err || cmd_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {frame_valid, frame_err, cmd_err}, 3'b000);
      end else begin
        e = exp_q.pop_front();
        check("frame_valid", frame_valid, e[126]);
        check("frame_err", frame_err, e[125]);
        check("cmd_err", cmd_err, e[124]);
        check("frame_cnt", frame_cnt, e[123:108]);
        check("dac_codes", dac_codes, e[107:0]);
      end
    end
  end

  initial begin
    #3ms;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic check_zero(input string tag);
    check({tag, "_codes"}, dac_codes, '0);
    check({tag, "_cnt"}, frame_cnt, '0);
    check({tag, "_pulses"}, {frame_valid, frame_err, cmd_err}, 3'b000);
    check({tag, "_sdo"}, sdo, 1'b0);
  endtask

  initial begin
    logic [31:0]  rw;
    logic [3:0]   cmd, addr;
    logic [255:0] b;
    int           n, r;

    model_reset();
    #20;
    check_zero("reset");
    rst_n = 1'b1;
    #100;

    // Good frame, command 3
    run_frame(mkf(32'h0030ABC0, 32'h00301230, 32'h00300FF0), 96);
    check("ch6", dac_codes[6*12 +: 12], 12'hABC);
    check("ch3", dac_codes[3*12 +: 12], 12'h123);
    check("ch0", dac_codes[0*12 +: 12], 12'h0FF);

    // Sweep: channel k gets 0x100+k
    for (int a = 0; a < 3; a++)
      run_frame(mkf(mkw(4'h3, 4'(a), 12'(12'h100 + 6 + a)),
                    mkw(4'h3, 4'(a), 12'(12'h100 + 3 + a)),
                    mkw(4'h3, 4'(a), 12'(12'h100 + a))), 96);
    for (int k = 0; k < 9; k++) check("sweep_ch", dac_codes[12*k +: 12], 12'(12'h100 + k));
    check("sweep_cnt", frame_cnt, 16'd4);

    // Framing boundaries: short, long, saturating-long, glitch
    run_frame(rnd_bits(), 95);
    check("short_cnt", frame_cnt, 16'd4);
    run_frame(rnd_bits(), 97);
    run_frame(rnd_bits(), 224);
    run_frame(rnd_bits(), 0);

    // Staged write then update
    run_frame(mkf(32'h00F00000, 32'h00F00000, mkw(4'h0, 4'h1, 12'h555)), 96);
    check("staged_hold", dac_codes[1*12 +: 12], 12'h101);
    run_frame(mkf(32'h00F00000, 32'h00F00000, mkw(4'h1, 4'h1, 12'h000)), 96);
    check("staged_upd", dac_codes[1*12 +: 12], 12'h555);

    // Bad command in chip 2 word
    run_frame(mkf(mkw(4'h3, 4'h2, 12'h9A1), mkw(4'h5, 4'h0, 12'h777), mkw(4'h3, 4'h2, 12'h3C4)), 96);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      run_frame(rnd_bits(), $urandom_range(1, 95));
      else if (r == 1) run_frame(rnd_bits(), $urandom_range(97, 200));
      else begin
        b = '0;
        for (int c = 0; c < 3; c++) begin
          rw = $urandom();
          case ($urandom_range(0, 6))
            0: cmd = 4'h0;
            1: cmd = 4'h1;
            2: cmd = 4'h2;
            3: cmd = 4'h3;
            4: cmd = 4'hF;
            5: cmd = 4'($urandom_range(0, 15));
            default: cmd = 4'h3;
          endcase
          addr = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
          b[32*c +: 32] = {rw[31:24], cmd, addr, rw[15:0]};
        end
        run_frame(b, 96);
      end
    end

    // Reset at bit 40, then a good frame
    track = 1'b1;
    cs_n  = 1'b0;
    #50;
    for (int i = 0; i < 40; i++) sclk_bit(1'($urandom_range(0, 1)), i == 0);
    #10;
    rst_n = 1'b0;
    model_reset();
    #20;
    check_zero("midreset");
    cs_n = 1'b1;
    #50;
    rst_n = 1'b1;
    track = 1'b0;
    #300;
    run_frame(mkf(mkw(4'h3, 4'h1, 12'hDEF), mkw(4'h2, 4'h0, 12'h246), mkw(4'h3, 4'h2, 12'h8E1)), 96);
    check("recover_cnt", frame_cnt, 16'd1);

    // Reset released with cs_n already low: the following clocks must be ignored
    cs_n = 1'b0;
    #50;
    track = 1'b1;
    for (int i = 0; i < 10; i++) sclk_bit(1'($urandom_range(0, 1)), i == 0);
    rst_n = 1'b0;
    model_reset();
    #20;
    rst_n = 1'b1;
    track = 1'b0;
    #200;
    b = rnd_bits();
    for (int i = 95; i >= 0; i--) sclk_bit(b[i], i == 95);
    #25;
    cs_n = 1'b1;
    #300;
    check("lowrel_cnt", frame_cnt, 16'd0);
    run_frame(mkf(mkw(4'h3, 4'h0, 12'h5A5), mkw(4'h3, 4'h0, 12'hA5A), mkw(4'h3, 4'h0, 12'h3C3)), 96);

    #500;
    check("queue_empty", exp_q.size(), 0);
    check("final_codes", dac_codes, model_codes());
    check("final_cnt", frame_cnt, m_cnt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
